// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ requesters, the arbiter and one FIFO write port.
// master = arbiter view, slave = requester/FIFO environment view.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  full;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  wr_en;
  logic [WIDTH-1:0]      wdata;
  logic [IDX_W-1:0]      owner;
  logic                  busy;

  modport master (
    input  req, req_data, full,
    output gnt, ack, wr_en, wdata, owner, busy
  );

  modport slave (
    output req, req_data, full,
    input  gnt, ack, wr_en, wdata, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of one FIFO write port; bursts of up to MAX_BURST words, one-cycle grant latency.
// Never writes while full: a full FIFO stalls the burst in place, and a bubble cycle separates grants.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  localparam int IDX_W    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              res,
  fifo_wr_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             busy_w;
  logic             wr_en_w;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Scan downwards from the farthest candidate so the nearest one after last_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NREQ);
      if (bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    busy_w    = (state_q == ST_BURST);
    wr_en_w   = busy_w && bus.req[owner_q] && !bus.full;
    bus.busy  = busy_w;
    bus.wr_en = wr_en_w;
    bus.owner = owner_q;
    bus.gnt   = busy_w  ? (NREQ'(1) << owner_q) : '0;
    bus.ack   = wr_en_w ? (NREQ'(1) << owner_q) : '0;
    bus.wdata = busy_w  ? bus.req_data[int'(owner_q)*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.full && pick_vld) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!bus.req[owner_q]) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (!bus.full) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last resets to NREQ-1 so that requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level arbiter model.
module tb_fifo_wr_arbiter;
  localparam int WIDTH     = 8;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;

  logic clk;
  logic res;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester side: words remaining, current word, and whether it is willing to request.
  int               rem [NREQ];
  logic [WIDTH-1:0] wd  [NREQ];
  bit               en  [NREQ];
  logic [NREQ-1:0]  reqv;

  // Arbiter model: who owns the port, who owned it last, words written this grant.
  bit m_busy;
  int m_own;
  int m_last;
  int m_done;

  // Observations from the most recent cycle.
  logic [NREQ-1:0]  s_gnt;
  logic             s_wr;
  logic             s_busy;
  logic [1:0]       s_own;
  logic [WIDTH-1:0] s_wd;
  bit               prev_busy;
  int               cyc;
  logic [WIDTH-1:0] wq[$];
  int               wcyc[$];
  int               gq[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      reqv[i] = (rem[i] > 0) && en[i];
      bus.req_data[i*WIDTH +: WIDTH] = wd[i];
    end
    bus.req = reqv;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      en[i]  = 1'b1;
      wd[i]  = '0;
    end
    bus.full = 1'b0;
  endtask

  task automatic run_cycle();
    logic [NREQ-1:0]  e_gnt;
    logic [NREQ-1:0]  e_ack;
    logic             e_wr;
    logic [WIDTH-1:0] e_wd;
    int               c;
    drive_reqs();
    #1;
    e_gnt = m_busy ? (NREQ'(1) << m_own) : '0;
    e_wr  = m_busy && reqv[m_own] && !bus.full;
    e_ack = e_wr ? e_gnt : '0;
    e_wd  = m_busy ? wd[m_own] : '0;
    check("gnt",    32'(bus.gnt),   32'(e_gnt));
    check("ack",    32'(bus.ack),   32'(e_ack));
    check("wr_en",  32'(bus.wr_en), 32'(e_wr));
    check("wdata",  32'(bus.wdata), 32'(e_wd));
    check("busy",   32'(bus.busy),  32'(m_busy));
    check("owner",  32'(bus.owner), 32'(m_own));
    check("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    s_gnt  = bus.gnt;
    s_wr   = bus.wr_en;
    s_busy = bus.busy;
    s_own  = bus.owner;
    s_wd   = bus.wdata;
    if (bus.wr_en === 1'b1) begin
      wq.push_back(bus.wdata);
      wcyc.push_back(cyc);
    end
    if (bus.busy === 1'b1 && !prev_busy) gq.push_back(int'(bus.owner));
    prev_busy = (bus.busy === 1'b1);
    @(posedge clk);
    if (res) begin
      m_busy = 1'b0;
      m_own  = 0;
      m_last = NREQ - 1;
      m_done = 0;
    end else if (!m_busy) begin
      if (!bus.full && (reqv != '0)) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (reqv[c]) begin
            m_own = c;
            break;
          end
        end
        m_busy = 1'b1;
        m_done = 0;
      end
    end else if (!reqv[m_own]) begin
      m_busy = 1'b0;
      m_last = m_own;
    end else if (!bus.full) begin
      m_done++;
      if (m_done == MAX_BURST) begin
        m_busy = 1'b0;
        m_last = m_own;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (e_ack[i]) begin
        rem[i]--;
        wd[i] = wd[i] + 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    res = 1'b1;
    run_cycle();
    res = 1'b0;
  endtask

  initial begin
    res       = 1'b1;
    bus.req   = '0;
    bus.req_data = '0;
    bus.full  = 1'b0;
    reqv      = '0;
    prev_busy = 1'b0;
    cyc       = 0;
    clear_reqs();
    @(posedge clk);
    @(negedge clk);
    m_busy = 1'b0;
    m_own  = 0;
    m_last = NREQ - 1;
    m_done = 0;

    // Reset with every requester asking.
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 1;
      wd[i]  = WIDTH'(8'hA0 + i);
    end
    run_cycle();
    run_cycle();
    check("rst_gnt",   32'(s_gnt),  32'd0);
    check("rst_wr",    32'(s_wr),   32'd0);
    check("rst_wdata", 32'(s_wd),   32'd0);
    check("rst_busy",  32'(s_busy), 32'd0);
    check("rst_owner", 32'(s_own),  32'd0);
    res = 1'b0;
    run_cycle();
    run_cycle();
    check("first_grant_busy",  32'(s_busy), 32'd1);
    check("first_grant_owner", 32'(s_own),  32'd0);
    repeat (12) run_cycle();

    // Burst limit with a single requester.
    clear_reqs();
    reset_dut();
    rem[2] = 6;
    wd[2]  = 8'h10;
    wq.delete();
    wcyc.delete();
    repeat (12) run_cycle();
    check("bl_count", 32'(wq.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      check("bl_data", (k < wq.size()) ? 32'(wq[k]) : 32'hFFFF, 32'(8'h10 + k));
    check("bl_bubble", (wcyc.size() >= 5) ? 32'(wcyc[4] - wcyc[3]) : 32'hFFFF, 32'd2);
    rem[1] = 1;
    rem[3] = 1;
    gq.delete();
    repeat (3) run_cycle();
    check("bl_next_owner", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF, 32'd3);
    repeat (8) run_cycle();

    // Round-robin with all requesters saturated.
    clear_reqs();
    reset_dut();
    for (int i = 0; i < NREQ; i++) rem[i] = 1000;
    gq.delete();
    repeat (42) run_cycle();
    check("rr_grants", 32'(gq.size() >= 8), 32'd1);
    for (int k = 0; k < 8; k++)
      check("rr_order", (k < gq.size()) ? 32'(gq[k]) : 32'hFFFF, 32'(k % NREQ));

    // Full stall mid-burst.
    clear_reqs();
    reset_dut();
    rem[1] = 10;
    wq.delete();
    repeat (3) run_cycle();
    bus.full = 1'b1;
    repeat (3) begin
      run_cycle();
      check("stall_gnt", 32'(s_gnt), 32'b0010);
      check("stall_wr",  32'(s_wr),  32'd0);
    end
    bus.full = 1'b0;
    repeat (3) run_cycle();
    check("stall_total", 32'(wq.size()), 32'd4);
    check("stall_idle",  32'(s_busy),    32'd0);

    // Early release by requester 1.
    clear_reqs();
    reset_dut();
    rem[1] = 2;
    run_cycle();
    rem[0] = 5;
    rem[3] = 5;
    repeat (4) run_cycle();
    check("rel_idle", 32'(s_busy), 32'd0);
    run_cycle();
    check("rel_busy",  32'(s_busy), 32'd1);
    check("rel_owner", 32'(s_own),  32'd3);

    // Reset in the middle of a burst.
    clear_reqs();
    reset_dut();
    rem[2] = 8;
    repeat (3) run_cycle();
    res    = 1'b1;
    rem[0] = 3;
    run_cycle();
    res = 1'b0;
    run_cycle();
    check("mid_rst_busy", 32'(s_busy), 32'd0);
    check("mid_rst_wr",   32'(s_wr),   32'd0);
    run_cycle();
    check("mid_rst_owner", 32'(s_own), 32'd0);

    // Random traffic.
    clear_reqs();
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
          rem[i] = $urandom_range(1, 7);
          wd[i]  = WIDTH'($urandom);
        end
        if ($urandom_range(0, 7) == 0) en[i] = !en[i];
      end
      bus.full = ($urandom_range(0, 3) == 0);
      res      = ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    res = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of a FIFO (asfifo write side, or a synchronous FIFO) among NREQ requesters. It runs in the FIFO write clock domain. It grants one requester at a time for a burst of up to MAX_BURST words and never presents a write while the FIFO reports full, so FIFO `overflow` cannot be set through this block.

## Interface
Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- NREQ, 4, number of requesters; 2 to 16.
- MAX_BURST, 4, maximum words per grant; 1 to 256.
- IDX_W, $clog2(NREQ), owner index width; derived, not overridden.

Ports:
- clk, input, 1, single clock: the FIFO write clock.
- res, input, 1, synchronous reset, active-high, sampled on posedge clk.
- req, input, NREQ, per-requester request; held high while the requester has data.
- req_data, input, NREQ*WIDTH, packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- full, input, 1, FIFO full flag.
- gnt, output, NREQ, one-hot ownership; all zero when no requester owns the port.
- ack, output, NREQ, one-hot: requester i's word is written this cycle.
- wr_en, output, 1, FIFO write enable.
- wdata, output, WIDTH, FIFO write data.
- owner, output, IDX_W, index of the current owner; valid when busy=1.
- busy, output, 1, high in the BURST state.

## Operation
- Two states: IDLE and BURST.
- Registered state:
  - `state`
  - `owner` (IDX_W)
  - `last` (IDX_W): last owner
  - `cnt`: width $clog2(MAX_BURST)+1
- Outputs are combinational from the registers plus the current req and full:
  - busy = (state==BURST).
  - gnt[i] = busy && owner==i.
  - wr_en = busy && req[owner] && !full.
  - ack[i] = gnt[i] && wr_en.
  - wdata = req_data slice of owner when busy, 0 otherwise.
- Reset (res=1 at posedge):
  - state=IDLE, owner=0, cnt=0, last=NREQ-1, so requester 0 has first priority.
  - Resulting outputs: gnt=0, ack=0, wr_en=0, wdata=0, busy=0, owner=0.
- IDLE:
  - If full=0 and any req bit is set, pick the first set bit scanning last+1, last+2, … with modulo-NREQ wrap.
  - Load that index into owner, set cnt=0, go to BURST.
  - If full=1, or no req bit is set, stay in IDLE; no grant is issued.
- BURST:
  - Transfer cycle (wr_en=1): cnt=cnt+1. If cnt==MAX_BURST-1 before the increment, go to IDLE and set last=owner.
  - req[owner]=0: go to IDLE and set last=owner. No write that cycle.
  - req[owner]=1 and full=1: stall. Hold state, owner and cnt. wr_en=0, gnt stays high. There is no timeout.
- Wrap-around: the round-robin pointer wraps NREQ-1 → 0. A sole active requester is re-granted after each burst.
- Requests from other requesters during a burst are ignored until the burst ends; no preemption.
- Requester contract:
  - Data for requester i must be stable whenever req[i]=1.
  - The requester advances to its next word on the cycle after ack[i]=1.
  - The requester may drop req at any time.

## Timing
- Arbitration latency: req seen in IDLE at edge t → gnt, busy and the first possible wr_en in the cycle after edge t (1 cycle).
- Every burst ends with at least one IDLE cycle, so one bubble separates consecutive grants. Maximum throughput is MAX_BURST/(MAX_BURST+1).
- A full burst with no stalls: MAX_BURST consecutive wr_en cycles, then IDLE.
- full is sampled combinationally in the same cycle as wr_en; wr_en=1 together with full=1 must never occur.
- Reset asserted mid-burst: on the next edge the block is in IDLE and all outputs follow the reset values. The partial burst is abandoned; words already acked remain written.
- Reset has priority over every other input.

## Test plan
- Reset values: hold res=1 for 2 cycles with every req bit high → gnt=0, ack=0, wr_en=0, wdata=0, busy=0, owner=0. After res falls, the first grant goes to requester 0.
- Burst limit: MAX_BURST=4, only req[2] high, data 0x10..0x15 advanced on ack, full=0 → writes 0x10..0x13, one IDLE cycle, then 0x14, 0x15. req[2] drops after the last ack → IDLE, last=2.
- Round-robin: all 4 req high continuously, each requester holding a constant word → grant order 0,1,2,3,0,…; each grant gives 4 writes followed by a 1-cycle bubble; gnt is one-hot at all times.
- Full stall: mid-burst, set full=1 for 3 cycles → wr_en=0 and gnt held for 3 cycles, cnt unchanged. The burst then completes its remaining words, still totalling 4.
- Early release: requester 1 drops req after 2 acks → IDLE the next cycle, last=1. If req[0] and req[3] are pending, requester 3 is granted next.
- Reset mid-burst: assert res after the 2nd write of a burst → wr_en=0 on the next cycle, busy=0. After reset, arbitration restarts at requester 0.
